// File: rtl/digit_score_sched.sv
// Frame-level scoring controller: accumulates per-class block scores, adds bias, argmaxes.
// Optional runner-up margin output enabled by defining DIGIT_SCORE_MARGIN_EN.
module digit_score_sched #(
   parameter int DEBIT      = 22,
   parameter int ACC_W      = 32,
   parameter int NUM_BLOCKS = 784,
   parameter int UP         = 108,
   parameter int DOWN       = 164,
   parameter int LEFT       = 212,
   parameter logic [10*ACC_W-1:0] BIAS = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [10:0]              xpos,
   input  logic [10:0]              ypos,
   input  logic                     blk_done,
   input  logic [10*(DEBIT+1)-1:0]  blk_scores,
   input  logic                     res_ready,
   output logic                     res_valid,
   output logic [3:0]               res_digit,
   output logic signed [ACC_W-1:0]  res_score,
`ifdef DIGIT_SCORE_MARGIN_EN
   output logic signed [ACC_W-1:0]  res_margin,
`endif
   output logic                     busy,
   output logic                     err_overrun,
   output logic                     err_short
);

   localparam int SW    = DEBIT + 1;
   localparam int CNT_W = $clog2(NUM_BLOCKS + 1);

   typedef enum logic [2:0] {IDLE, ACCUM, BIAS_ADD, ARGMAX, RESULT} state_t;

   function automatic logic signed [ACC_W-1:0] sext_score(input logic [SW-1:0] s);
      return ACC_W'(signed'(s));
   endfunction

   function automatic logic signed [ACC_W-1:0] bias_of(input int i);
      return signed'(BIAS[i*ACC_W +: ACC_W]);
   endfunction

   state_t                   state;
   logic signed [ACC_W-1:0]  acc [10];
   logic [CNT_W-1:0]         done_cnt;
   logic [3:0]               idx;
   logic [3:0]               best_idx;
   logic signed [ACC_W-1:0]  best;
   logic signed [ACC_W-1:0]  cand;
   logic signed [ACC_W-1:0]  best_nxt;
   logic [3:0]               best_idx_nxt;
   logic                     cand_wins;
   logic                     frame_start;
   logic                     window_end;
   logic                     last_blk;

   assign frame_start = (xpos == 11'(LEFT)) && (ypos == 11'(UP));
   assign window_end  = (xpos == 11'(LEFT)) && (ypos == 11'(DOWN + 1));
   assign last_blk    = blk_done && (done_cnt == CNT_W'(NUM_BLOCKS - 1));
   assign busy        = (state == ACCUM) || (state == BIAS_ADD) || (state == ARGMAX);

   assign cand         = acc[idx];
   assign cand_wins    = cand > best;
   assign best_nxt     = cand_wins ? cand : best;
   assign best_idx_nxt = cand_wins ? idx : best_idx;

`ifdef DIGIT_SCORE_MARGIN_EN
   logic signed [ACC_W-1:0] second;
   logic signed [ACC_W-1:0] second_nxt;
   // A displaced best becomes runner-up; a tie with best lands here too, giving margin 0.
   assign second_nxt = cand_wins ? best : ((cand > second) ? cand : second);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         for (int i = 0; i < 10; i++) acc[i] <= '0;
         done_cnt    <= '0;
         idx         <= '0;
         best_idx    <= '0;
         best        <= '0;
         res_valid   <= 1'b0;
         res_digit   <= '0;
         res_score   <= '0;
         err_overrun <= 1'b0;
         err_short   <= 1'b0;
`ifdef DIGIT_SCORE_MARGIN_EN
         second      <= '0;
         res_margin  <= '0;
`endif
      end else begin
         err_overrun <= frame_start &&
                        (state == BIAS_ADD || state == ARGMAX || state == RESULT);
         err_short   <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  for (int i = 0; i < 10; i++) acc[i] <= '0;
                  done_cnt <= '0;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               // The final completion outranks a coincident frame start.
               if (last_blk) begin
                  for (int i = 0; i < 10; i++)
                     acc[i] <= acc[i] + sext_score(blk_scores[i*SW +: SW]);
                  done_cnt    <= done_cnt + 1'b1;
                  err_overrun <= frame_start;
                  state       <= BIAS_ADD;
               end else if (frame_start && done_cnt != '0) begin
                  for (int i = 0; i < 10; i++) acc[i] <= '0;
                  done_cnt    <= '0;
                  err_overrun <= 1'b1;
               end else if (window_end) begin
                  err_short <= 1'b1;
                  state     <= IDLE;
               end else if (blk_done) begin
                  for (int i = 0; i < 10; i++)
                     acc[i] <= acc[i] + sext_score(blk_scores[i*SW +: SW]);
                  done_cnt <= done_cnt + 1'b1;
               end
            end
            BIAS_ADD: begin
               for (int i = 0; i < 10; i++) acc[i] <= acc[i] + bias_of(i);
               best     <= acc[0] + bias_of(0);
               best_idx <= '0;
               idx      <= 4'd1;
`ifdef DIGIT_SCORE_MARGIN_EN
               second   <= {1'b1, {(ACC_W-1){1'b0}}};
`endif
               state    <= ARGMAX;
            end
            ARGMAX: begin
               best     <= best_nxt;
               best_idx <= best_idx_nxt;
`ifdef DIGIT_SCORE_MARGIN_EN
               second   <= second_nxt;
`endif
               if (idx == 4'd9) begin
                  res_valid  <= 1'b1;
                  res_digit  <= best_idx_nxt;
                  res_score  <= best_nxt;
`ifdef DIGIT_SCORE_MARGIN_EN
                  res_margin <= best_nxt - second_nxt;
`endif
                  state      <= RESULT;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_digit_score_sched.sv
// Directed bench for digit_score_sched: two instances (zero bias, class0 bias +100) fed identical stimulus.
module tb_digit_score_sched;

   localparam int DEBIT = 22;
   localparam int SW    = DEBIT + 1;
   localparam int ACC_W = 32;
   localparam int NB    = 4;
   localparam int UP    = 108;
   localparam int DOWN  = 164;
   localparam int LEFT  = 212;
   localparam logic [10*ACC_W-1:0] BIAS1 = (10*ACC_W)'(100);

   typedef struct {
      int d;
      int s;
      int m;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [10:0] xpos = '0;
   logic [10:0] ypos = '0;
   logic blk_done = 1'b0;
   logic [10*SW-1:0] blk_scores = '0;
   logic res_ready = 1'b1;

   logic res_valid0, res_valid1, busy0, busy1;
   logic err_overrun0, err_overrun1, err_short0, err_short1;
   logic [3:0] res_digit0, res_digit1;
   logic signed [ACC_W-1:0] res_score0, res_score1;
`ifdef DIGIT_SCORE_MARGIN_EN
   logic signed [ACC_W-1:0] res_margin0, res_margin1;
`endif

   exp_t q0[$];
   exp_t q1[$];
   int frm [NB][10];
   int passed = 0;
   int total = 0;
   int exp_d, exp_s;

   always #5 clk = ~clk;

   digit_score_sched #(.DEBIT(DEBIT), .ACC_W(ACC_W), .NUM_BLOCKS(NB),
                       .UP(UP), .DOWN(DOWN), .LEFT(LEFT), .BIAS('0)) dut0 (
      .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos),
      .blk_done(blk_done), .blk_scores(blk_scores), .res_ready(res_ready),
      .res_valid(res_valid0), .res_digit(res_digit0), .res_score(res_score0),
`ifdef DIGIT_SCORE_MARGIN_EN
      .res_margin(res_margin0),
`endif
      .busy(busy0), .err_overrun(err_overrun0), .err_short(err_short0));

   digit_score_sched #(.DEBIT(DEBIT), .ACC_W(ACC_W), .NUM_BLOCKS(NB),
                       .UP(UP), .DOWN(DOWN), .LEFT(LEFT), .BIAS(BIAS1)) dut1 (
      .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos),
      .blk_done(blk_done), .blk_scores(blk_scores), .res_ready(res_ready),
      .res_valid(res_valid1), .res_digit(res_digit1), .res_score(res_score1),
`ifdef DIGIT_SCORE_MARGIN_EN
      .res_margin(res_margin1),
`endif
      .busy(busy1), .err_overrun(err_overrun1), .err_short(err_short1));

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: lowest index holding the maximum; margin against best of the others.
   function automatic exp_t predict(input int bias0);
      int t[10];
      int sec;
      bit have;
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         t[i] = 0;
         for (int b = 0; b < NB; b++) t[i] += frm[b][i];
      end
      t[0] += bias0;
      e.d = 0;
      for (int i = 1; i < 10; i++) if (t[i] > t[e.d]) e.d = i;
      e.s = t[e.d];
      have = 0;
      sec = 0;
      for (int j = 0; j < 10; j++)
         if (j != e.d && (!have || t[j] > sec)) begin
            sec = t[j];
            have = 1;
         end
      e.m = e.s - sec;
      return e;
   endfunction

   task automatic drive_block(input int b);
      blk_done = 1'b1;
      for (int i = 0; i < 10; i++) blk_scores[i*SW +: SW] = frm[b][i][SW-1:0];
   endtask

   task automatic idle_inputs();
      blk_done = 1'b0;
      blk_scores = '0;
      xpos = '0;
      ypos = '0;
   endtask

   task automatic frame_start_cycle();
      xpos = 11'(LEFT);
      ypos = 11'(UP);
      tick();
      xpos = '0;
      ypos = '0;
   endtask

   task automatic run_frame(input bit junk, input bit ready, input string tag);
      exp_t e0, e1;
      int n;
      e0 = predict(0);
      e1 = predict(100);
      res_ready = ready;
      frame_start_cycle();
      check({tag, "_busy"}, busy0, 1);
      if (junk) begin
         blk_done = 1'b1;
         for (int i = 0; i < 10; i++) blk_scores[i*SW +: SW] = SW'(50);
         tick();
         idle_inputs();
         frame_start_cycle();
         check({tag, "_restart_overrun"}, err_overrun0, 1);
      end
      for (int b = 0; b < NB; b++) begin
         if (b == 2) tick();
         drive_block(b);
         if (b == NB - 1) begin
            q0.push_back(e0);
            q1.push_back(e1);
         end
         tick();
         idle_inputs();
      end
      n = 0;
      while (!res_valid0 && n < 30) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, n, 10);
      exp_d = e0.d;
      exp_s = e0.s;
      if (ready) begin
         tick();
         check({tag, "_valid_drop"}, res_valid0, 0);
         check({tag, "_idle"}, busy0, 0);
         check({tag, "_digit_hold"}, res_digit0, e0.d);
      end
   endtask

   logic pv0 = 1'b0;
   logic pv1 = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (res_valid0 && !pv0) begin
         if (q0.size() == 0) check("unexpected_valid0", 1, 0);
         else begin
            e = q0.pop_front();
            check("digit0", res_digit0, e.d);
            check("score0", res_score0, e.s);
`ifdef DIGIT_SCORE_MARGIN_EN
            check("margin0", res_margin0, e.m);
`endif
         end
      end
      if (res_valid1 && !pv1) begin
         if (q1.size() == 0) check("unexpected_valid1", 1, 0);
         else begin
            e = q1.pop_front();
            check("digit1", res_digit1, e.d);
            check("score1", res_score1, e.s);
`ifdef DIGIT_SCORE_MARGIN_EN
            check("margin1", res_margin1, e.m);
`endif
         end
      end
      pv0 <= res_valid0;
      pv1 <= res_valid1;
   end

   initial begin
      int ovr, unstable;
      tick();
      tick();
      check("rst_valid", res_valid0, 0);
      check("rst_digit", res_digit0, 0);
      check("rst_score", res_score0, 0);
      check("rst_busy", busy0, 0);
      check("rst_overrun", err_overrun0, 0);
      check("rst_short", err_short0, 0);
      rst_n = 1'b1;
      tick();

      // Class 3 dominant.
      for (int b = 0; b < NB; b++) for (int i = 0; i < 10; i++) frm[b][i] = (i == 3) ? 5 : 1;
      run_frame(0, 1, "t1");

      // Tie between classes 2 and 7, preceded by a restarted frame.
      for (int b = 0; b < NB; b++) for (int i = 0; i < 10; i++) frm[b][i] = (i == 2 || i == 7) ? 3 : 1;
      run_frame(1, 1, "t2");

      // All negative totals.
      for (int b = 0; b < NB; b++) for (int i = 0; i < 10; i++) frm[b][i] = -(10 - i);
      run_frame(0, 1, "t3");

      // Mixed pattern with a stalled consumer and a frame start during RESULT.
      for (int b = 0; b < NB; b++) for (int i = 0; i < 10; i++) frm[b][i] = ((i * 7 + b * 3) % 11) - 5;
      run_frame(0, 0, "t4");
      ovr = 0;
      unstable = 0;
      for (int k = 0; k < 20; k++) begin
         if (k == 5) begin
            xpos = 11'(LEFT);
            ypos = 11'(UP);
         end
         tick();
         xpos = '0;
         ypos = '0;
         if (err_overrun0) ovr++;
         if (res_valid0 !== 1'b1 || res_digit0 !== 4'(exp_d) || res_score0 !== exp_s) unstable++;
      end
      check("t4_stable", unstable, 0);
      check("t4_overrun_pulses", ovr, 1);
      res_ready = 1'b1;
      tick();
      check("t4_valid_drop", res_valid0, 0);
      check("t4_idle", busy0, 0);

      // Short frame: only two completions before the window ends.
      frame_start_cycle();
      for (int b = 0; b < 2; b++) begin
         drive_block(b);
         tick();
         idle_inputs();
      end
      xpos = 11'(LEFT);
      ypos = 11'(DOWN + 1);
      tick();
      xpos = '0;
      ypos = '0;
      check("t5_short_pulse", err_short0, 1);
      check("t5_busy", busy0, 0);
      tick();
      check("t5_short_clear", err_short0, 0);
      repeat (12) tick();
      check("t5_no_valid", res_valid0, 0);

      // Reset mid-frame, then a clean frame.
      for (int b = 0; b < NB; b++) for (int i = 0; i < 10; i++) frm[b][i] = (i == 1) ? 1000 : 7;
      frame_start_cycle();
      for (int b = 0; b < 2; b++) begin
         drive_block(b);
         tick();
         idle_inputs();
      end
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", res_valid0, 0);
      check("t6_rst_digit", res_digit0, 0);
      check("t6_rst_score", res_score0, 0);
      check("t6_rst_busy", busy0, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int b = 0; b < NB; b++) for (int i = 0; i < 10; i++) frm[b][i] = (i == 8) ? 2 : -1;
      run_frame(0, 1, "t6");

      repeat (3) tick();
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/digit_score_sched.md
Name: digit_score_sched

Overview:
- Frame-level controller for the 28x28 per-block scoring array.
- Arms on the scan position at frame start and accumulates the ten class scores pulsed out by the block instances. The block outputs are OR-merged upstream; each block drives zero when not done.
- After NUM_BLOCKS completions it adds per-class bias and runs a sequential argmax over the ten classes.
- Presents the predicted digit to the display/UART stage with a valid/ready handshake.

Parameters:
- DEBIT, 22: MSB index of each signed block score (score width DEBIT+1).
- ACC_W, 32: signed accumulator/result width.
- NUM_BLOCKS, 784: block completions expected per frame.
- UP, 108: top boundary of the digit window (exclusive).
- DOWN, 164: bottom boundary of the digit window (exclusive).
- LEFT, 212: left boundary of the digit window (exclusive).
- BIAS, 0: packed 10*ACC_W signed per-class bias; class i occupies [i*ACC_W +: ACC_W].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- xpos  in  11  current scan x.
- ypos  in  11  current scan y.
- blk_done  in  1  OR of all block res_done pulses; one cycle per block completion.
- blk_scores  in  10*(DEBIT+1)  OR-merged signed block scores; class i at [i*(DEBIT+1) +: DEBIT+1]; valid only when blk_done=1.
- res_ready  in  1  consumer accepts the result.
- res_valid  out  1  result available.
- res_digit  out  4  winning class, 0..9.
- res_score  out  ACC_W  signed winning total, bias included.
- busy  out  1  high in any state other than IDLE and RESULT.
- err_overrun  out  1  one-cycle pulse when a frame start is dropped or a frame is restarted.
- err_short  out  1  one-cycle pulse when the window ends with fewer than NUM_BLOCKS completions.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; all accumulators, done_cnt, res_valid, res_digit, res_score, err_* = 0.
- frame_start = (xpos==LEFT && ypos==UP). window_end = (ypos==DOWN+1 && xpos==LEFT).
- IDLE -> ACCUM on frame_start.
  - On entry, clear acc[0..9] and done_cnt.
- ACCUM, per cycle with blk_done=1:
  - acc[i] += sign-extended blk_scores field i.
  - done_cnt++.
  - blk_done=0: no change.
- ACCUM exits:
  - done_cnt reaches NUM_BLOCKS (sampled on the last blk_done): -> BIAS.
  - window_end with done_cnt<NUM_BLOCKS: pulse err_short, -> IDLE, no result produced.
  - frame_start with done_cnt>0: clear and restart ACCUM, pulse err_overrun.
  - frame_start on the same cycle as the final blk_done: the completion wins and goes to BIAS; the frame start is dropped with an err_overrun pulse.
- BIAS (1 cycle): acc[i] += BIAS field i. -> ARGMAX with best_idx=0, best=acc[0], idx=1.
- ARGMAX (9 cycles, one compare per cycle):
  - Signed compare: if acc[idx] > best, update best and best_idx.
  - Ties keep the lower index.
  - After idx=9 -> RESULT.
- Latency: res_valid rises on the 10th rising edge after the edge that samples the final blk_done.
- RESULT:
  - res_valid=1; res_digit and res_score are held stable while res_valid=1 and res_ready=0.
  - Transfer occurs when res_valid && res_ready. On that edge: res_valid->0, -> IDLE.
  - res_ready high at RESULT entry completes the transfer on the next edge.
  - After the transfer, res_digit and res_score hold their last values.
- frame_start in BIAS, ARGMAX or RESULT: ignored, err_overrun pulses once. A subsequent frame is accepted only from IDLE.
- blk_done outside ACCUM: ignored.
- Accumulation wraps modulo 2^ACC_W, with no saturation. Sizing ACC_W >= DEBIT+1+10 avoids overflow.
- Reset mid-operation aborts the current frame immediately.

Optional Feature:
- Macro: DIGIT_SCORE_MARGIN_EN.
- Defined:
  - Adds output res_margin (ACC_W, signed) = best minus second-best total.
  - ARGMAX tracks the runner-up in parallel: a displaced best becomes second; a tie with best sets margin 0.
  - Same latency; res_margin is held with res_digit.
- Undefined: the port and the second-best logic are absent. All other behaviour is identical.

Test Plan:
- NUM_BLOCKS=4, BIAS=0; four blk_done pulses with class3=5 and other classes=1 -> res_digit=3, res_score=20, res_valid exactly 10 edges after the 4th pulse.
- Classes 2 and 7 both total 12, others lower -> res_digit=2; with DIGIT_SCORE_MARGIN_EN, res_margin=0.
- All totals negative (class i = -(10-i)*4 over 4 blocks) -> res_digit=9, res_score=-4. With BIAS class0=+100 -> res_digit=0, res_score=60.
- res_ready low for 20 cycles after res_valid; frame_start pulsed meanwhile -> outputs stable, err_overrun single pulse, res_valid drops one edge after res_ready=1, state returns to IDLE.
- Only 2 of 4 blk_done pulses, then scan reaches ypos=DOWN+1, xpos=LEFT -> err_short pulse, no res_valid, busy=0.
- rst_n asserted low after 2 blk_done pulses -> all outputs 0 immediately. A new frame after release yields results from that frame's blocks only.
